// File: rtl/adc_trigger_fifo.sv
// rtl/adc_trigger_fifo.sv - ADC comparator sampler plus single-clock count-word FIFO
// Level is a register; flags decode it combinationally so they follow the access edge.
module adc_trigger_fifo #(
  parameter int DATA_W      = 24,
  parameter int DEPTH       = 8,
  parameter int AE_THRESH   = 1,
  parameter int AF_THRESH   = 7,
  parameter int SYNC_STAGES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     adc_comp,
  output logic                     adc_count,
  output logic                     adc_countn,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic                     fifo_clear,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] ONE_L   = LW'(1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   countn_q, countn_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [LW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_ok, rd_ok;

  // The complement is taken from the next value so both outputs flip on the same edge.
  always_comb begin
    sync_d    = '0;
    sync_d[0] = adc_comp;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    countn_d = ~sync_d[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      countn_q <= 1'b1;
    end else begin
      sync_q   <= sync_d;
      countn_q <= countn_d;
    end
  end

  assign adc_count  = sync_q[SYNC_STAGES-1];
  assign adc_countn = countn_q;

  assign empty        = (level_q == '0);
  assign full         = (level_q == DEPTH_L);
  assign almost_empty = (level_q <= AE_L);
  assign almost_full  = (level_q >= AF_L);
  assign level        = level_q;
  assign rd_data      = rd_data_q;

  // Acceptance uses the pre-edge flags, so a write at full is refused even alongside a read.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;
    if (fifo_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + ONE_L;
      end
      if (rd_ok) begin
        rd_ptr_d  = rd_ptr_q + ONE_L;
        rd_data_d = mem[rd_ptr_q[PW-1:0]];
      end
      case ({wr_ok, rd_ok})
        2'b10:   level_d = level_q + ONE_L;
        2'b01:   level_d = level_q - ONE_L;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !fifo_clear) begin
      mem[wr_ptr_q[PW-1:0]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_adc_trigger_fifo.sv
// tb/tb_adc_trigger_fifo.sv - directed self-checking bench for adc_trigger_fifo
module tb_adc_trigger_fifo;

  logic        clk;
  logic        rst_n;
  logic        adc_comp;
  logic        adc_count;
  logic        adc_countn;
  logic [23:0] wr_data;
  logic        wr_en;
  logic        rd_en;
  logic        fifo_clear;
  logic [23:0] rd_data;
  logic        empty;
  logic        full;
  logic        almost_empty;
  logic        almost_full;
  logic [3:0]  level;

  int pass_cnt = 0;
  int total_cnt = 0;

  adc_trigger_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .adc_comp     (adc_comp),
    .adc_count    (adc_count),
    .adc_countn   (adc_countn),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .fifo_clear   (fifo_clear),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .level        (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; fifo_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; adc_comp = 1'b0; wr_data = '0; idle();
    step(); step();
    total_cnt++;
    if (adc_countn !== 1'b1 || adc_count !== 1'b0) $display("FAIL reset_hold_trigger: count=%b countn=%b expected 0/1", adc_count, adc_countn);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
    total_cnt++;
    if ({adc_count, adc_countn, empty, almost_empty, full, almost_full} !== 6'b011100)
      $display("FAIL reset_flags: count/countn/e/ae/f/af=%b%b%b%b%b%b expected 011100", adc_count, adc_countn, empty, almost_empty, full, almost_full);
    else pass_cnt++;
    total_cnt++;
    if (level !== 4'd0 || rd_data !== 24'd0) $display("FAIL reset_level_data: level=%0d rd_data=%h expected 0/000000", level, rd_data);
    else pass_cnt++;
    adc_comp = 1'b1;
    step();
    total_cnt++;
    if (adc_count !== 1'b1 || adc_countn !== 1'b0) $display("FAIL trigger_rise: count=%b countn=%b expected 1/0", adc_count, adc_countn);
    else pass_cnt++;
    adc_comp = 1'b0;
    step();
    total_cnt++;
    if (adc_count !== 1'b0 || adc_countn !== 1'b1) $display("FAIL trigger_fall: count=%b countn=%b expected 0/1", adc_count, adc_countn);
    else pass_cnt++;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 24'(i);
      step();
      total_cnt++;
      if (level !== 4'(i) || almost_full !== (i >= 7) || full !== (i == 8) || empty !== 1'b0 || almost_empty !== (i <= 1))
        $display("FAIL fill_%0d: level=%0d af=%b f=%b e=%b ae=%b expected level %0d", i, level, almost_full, full, empty, almost_empty, i);
      else pass_cnt++;
    end
    wr_data = 24'hFFFFFF;
    step();
    idle();
    total_cnt++;
    if (level !== 4'd8 || full !== 1'b1) $display("FAIL fill_overflow: level=%0d full=%b expected 8/1", level, full);
    else pass_cnt++;
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
      step();
      total_cnt++;
      if (rd_data !== 24'(i) || level !== 4'(8 - i))
        $display("FAIL drain_%0d: rd_data=%h level=%0d expected %h/%0d", i, rd_data, level, 24'(i), 8 - i);
      else pass_cnt++;
    end
    step();
    idle();
    total_cnt++;
    if (rd_data !== 24'h000008 || empty !== 1'b1 || level !== 4'd0)
      $display("FAIL drain_underflow: rd_data=%h empty=%b level=%0d expected 000008/1/0", rd_data, empty, level);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [23:0] exp_rd [4];
    exp_rd[0] = 24'h10; exp_rd[1] = 24'h11; exp_rd[2] = 24'h12; exp_rd[3] = 24'h20;
    // move both pointers to address 6 so the next writes cross the wrap
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 24'h777; step();
      idle(); rd_en = 1'b1; step();
      idle();
    end
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 24'h10 + 24'(i); step();
    end
    idle();
    total_cnt++;
    if (level !== 4'd3) $display("FAIL wrap_prefill: level=%0d expected 3", level);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 24'h20 + 24'(i);
      step();
      total_cnt++;
      if (rd_data !== exp_rd[i] || level !== 4'd3)
        $display("FAIL wrap_rw_%0d: rd_data=%h level=%0d expected %h/3", i, rd_data, level, exp_rd[i]);
      else pass_cnt++;
    end
    idle();
    for (int i = 1; i <= 3; i++) begin
      rd_en = 1'b1; step();
      total_cnt++;
      if (rd_data !== 24'h20 + 24'(i)) $display("FAIL wrap_tail_%0d: rd_data=%h expected %h", i, rd_data, 24'h20 + 24'(i));
      else pass_cnt++;
    end
    idle();
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 24'h100 + 24'(i); step();
    end
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 24'hEEEEEE;
    step();
    idle();
    total_cnt++;
    if (rd_data !== 24'h100 || level !== 4'd7 || full !== 1'b0 || almost_full !== 1'b1)
      $display("FAIL full_rw: rd_data=%h level=%0d full=%b af=%b expected 000100/7/0/1", rd_data, level, full, almost_full);
    else pass_cnt++;
    for (int i = 1; i <= 7; i++) begin
      rd_en = 1'b1; step();
      total_cnt++;
      if (rd_data !== 24'h100 + 24'(i)) $display("FAIL full_rw_drain_%0d: rd_data=%h expected %h", i, rd_data, 24'h100 + 24'(i));
      else pass_cnt++;
    end
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 24'h55;
    step();
    idle();
    total_cnt++;
    if (level !== 4'd1 || rd_data !== 24'h107 || empty !== 1'b0)
      $display("FAIL empty_rw: level=%0d rd_data=%h empty=%b expected 1/000107/0", level, rd_data, empty);
    else pass_cnt++;
    rd_en = 1'b1; step(); idle();
    total_cnt++;
    if (rd_data !== 24'h55 || level !== 4'd0) $display("FAIL empty_rw_read: rd_data=%h level=%0d expected 000055/0", rd_data, level);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    adc_comp = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 24'h200 + 24'(i); step();
    end
    total_cnt++;
    if (level !== 4'd5) $display("FAIL clear_prefill: level=%0d expected 5", level);
    else pass_cnt++;
    fifo_clear = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 24'h999;
    step();
    idle();
    total_cnt++;
    if (level !== 4'd0 || empty !== 1'b1 || rd_data !== 24'h55)
      $display("FAIL clear: level=%0d empty=%b rd_data=%h expected 0/1/000055", level, empty, rd_data);
    else pass_cnt++;
    total_cnt++;
    if (adc_count !== 1'b1 || adc_countn !== 1'b0) $display("FAIL clear_trigger: count=%b countn=%b expected 1/0", adc_count, adc_countn);
    else pass_cnt++;
    wr_en = 1'b1; wr_data = 24'hABCDEF; step();
    idle(); rd_en = 1'b1; step(); idle();
    total_cnt++;
    if (rd_data !== 24'hABCDEF || level !== 4'd0) $display("FAIL clear_then_rw: rd_data=%h level=%0d expected abcdef/0", rd_data, level);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    wr_en = 1'b1; wr_data = 24'h300; step();
    wr_data = 24'h301; step();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({adc_count, adc_countn, empty, almost_empty, full, almost_full} !== 6'b011100 || level !== 4'd0 || rd_data !== 24'd0)
      $display("FAIL reset_mid: count/countn/e/ae/f/af=%b%b%b%b%b%b level=%0d rd_data=%h expected 011100/0/000000",
               adc_count, adc_countn, empty, almost_empty, full, almost_full, level, rd_data);
    else pass_cnt++;
    idle(); adc_comp = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    wr_en = 1'b1; wr_data = 24'h123; step();
    idle(); rd_en = 1'b1; step(); idle();
    total_cnt++;
    if (rd_data !== 24'h123 || level !== 4'd0) $display("FAIL reset_mid_recover: rd_data=%h level=%0d expected 000123/0", rd_data, level);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_full_rw();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
